outbox_fifo: RTL and testbench

Memory-mapped output port: the CPU writes bytes into an 8-entry FIFO with COPYTO, and a downstream consumer drains them over a valid/ready stream. It is the sink-direction counterpart of the PRNG peripheral. It shares the same address/data/write-enable bus and sits beside the PRNG on the peripheral decode. A status register gives the CPU occupancy and error flags for polling.

---
 rtl/outbox_fifo_pkg.sv | 20 ++
 rtl/outbox_fifo_mem.sv | 17 +
 rtl/outbox_fifo.sv | 75 +++++++
 tb/tb_outbox_fifo.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/outbox_fifo_pkg.sv
// outbox_fifo_pkg: shared peripheral addresses and outbox status/control bit positions
package outbox_fifo_pkg;
  localparam logic [7:0] PRNG_SEED_ADDR   = 8'h17;
  localparam logic [7:0] OUTBOX_DATA_ADDR = 8'h18;
  localparam logic [7:0] OUTBOX_STAT_ADDR = 8'h19;
  localparam int STAT_OVF     = 7;
  localparam int STAT_FULL    = 6;
  localparam int STAT_EMPTY   = 5;
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
  function automatic logic [7:0] stat_byte(input logic ovf, input logic full, input logic empty,
                                           input logic [3:0] cnt);
    logic [7:0] s;
    s = {4'h0, cnt};
    s[STAT_OVF]   = ovf;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    return s;
  endfunction
endpackage

// File: rtl/outbox_fifo_mem.sv
// outbox_fifo_mem: DEPTH x 8 register array, synchronous write, asynchronous read
module outbox_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/outbox_fifo.sv
// outbox_fifo: memory-mapped 8-bit outbox FIFO drained over valid/ready.
// Define OUTBOX_OVF_EN to enable the sticky overflow flag (status bit 7).
module outbox_fifo
  import outbox_fifo_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] DATA_ADDR = OUTBOX_DATA_ADDR,
  parameter logic [7:0] STAT_ADDR = OUTBOX_STAT_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic       write_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_ONE  = (AW+1)'(1);
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic [7:0]    r_dout;
  logic          w_full, w_empty, w_pop, w_push, w_data_wr, w_stat_wr, w_flush, w_ovf;
  logic [7:0]    w_stat, w_rd;
  assign w_full    = r_count == L_FULL;
  assign w_empty   = r_count == '0;
  assign w_pop     = ~w_empty & out_ready;
  assign w_data_wr = write_en & (addr == DATA_ADDR);
  assign w_stat_wr = write_en & (addr == STAT_ADDR);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the write
  assign w_push    = w_data_wr & (~w_full | w_pop);
  assign w_flush   = w_stat_wr & din[CTRL_FLUSH];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_push != w_pop) r_count <= w_push ? r_count + L_ONE : r_count - L_ONE;
    end
`ifdef OUTBOX_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_ovf <= 1'b0;
    else r_ovf <= (w_data_wr & ~w_push) | (r_ovf & ~(w_stat_wr & din[CTRL_CLR_OVF]));
  assign w_ovf = r_ovf;
`else
  assign w_ovf = 1'b0;
`endif
  assign w_stat = stat_byte(w_ovf, w_full, w_empty, 4'(r_count));
  assign w_rd   = (addr == DATA_ADDR) ? (w_empty ? 8'h00 : out_data) :
                  (addr == STAT_ADDR) ? w_stat : 8'h00;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_dout <= 8'h00;
    else r_dout <= w_rd;
  assign dout      = r_dout;
  assign out_valid = ~w_empty;
  outbox_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wp),
    .i_wdata (din),
    .i_raddr (r_rp),
    .o_rdata (out_data)
  );
endmodule

// File: tb/tb_outbox_fifo.sv
// tb_outbox_fifo: directed table, corner sequences and random traffic against a queue model
module tb_outbox_fifo;
  localparam logic [7:0] DATA = 8'h18;
  localparam logic [7:0] STAT = 8'h19;
  localparam int DEPTH = 8;
`ifdef OUTBOX_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, write_en = 1'b0, out_ready = 1'b0;
  logic [7:0] addr = 8'h00, din = 8'h00;
  logic [7:0] dout, out_data;
  logic out_valid;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] q[$];
  logic [7:0] drained[$];
  bit ovf = 1'b0;
  typedef struct {
    bit we; logic [7:0] a; logic [7:0] d; bit rdy;
    logic [7:0] dout; bit valid; logic [7:0] data;
  } vec_t;
  vec_t tbl[10];

  outbox_fifo dut (
    .clk(clk), .rst(rst), .addr(addr), .write_en(write_en), .din(din),
    .dout(dout), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] stat_model();
    return {ovf & OVF_EN, q.size() == DEPTH, q.size() == 0, 1'b0, 4'(q.size())};
  endfunction

  task automatic step(input bit we, input logic [7:0] a, input logic [7:0] d, input bit rdy);
    bit pop, push, flush, drop;
    logic [7:0] ed;
    write_en = we; addr = a; din = d; out_ready = rdy;
    ed = (a == DATA) ? (q.size() != 0 ? q[0] : 8'h00) : (a == STAT) ? stat_model() : 8'h00;
    pop   = q.size() != 0 && rdy;
    flush = we && a == STAT && d[0];
    push  = we && a == DATA && (q.size() < DEPTH || pop);
    drop  = we && a == DATA && !push;
    if (pop) drained.push_back(out_data);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
    if (OVF_EN) ovf = drop | (ovf & !(we && a == STAT && d[1]));
    #1;
    chk("dout", dout, ed);
    chk("out_valid", {7'b0, out_valid}, {7'b0, q.size() != 0});
    if (q.size() != 0) chk("out_data", out_data, q[0]);
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'h19, 8'h00, 1'b0, 8'h20, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h18, 8'h41, 1'b0, 8'h00, 1'b1, 8'h41};
    tbl[2] = '{1'b1, 8'h18, 8'h42, 1'b0, 8'h41, 1'b1, 8'h41};
    tbl[3] = '{1'b1, 8'h18, 8'h43, 1'b0, 8'h41, 1'b1, 8'h41};
    tbl[4] = '{1'b0, 8'h19, 8'h00, 1'b0, 8'h03, 1'b1, 8'h41};
    tbl[5] = '{1'b0, 8'h18, 8'h00, 1'b0, 8'h41, 1'b1, 8'h41};
    tbl[6] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 8'h42};
    tbl[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 8'h43};
    tbl[8] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[9] = '{1'b0, 8'h19, 8'h00, 1'b0, 8'h20, 1'b0, 8'h00};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_valid", {7'b0, out_valid}, 8'h00);
    @(negedge clk) rst = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
      chk($sformatf("tbl%0d_valid", i), {7'b0, out_valid}, {7'b0, tbl[i].valid});
      if (tbl[i].valid) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].data);
    end

    for (int i = 0; i < 8; i++) step(1'b1, DATA, 8'h10 + 8'(i), 1'b0);
    step(1'b1, DATA, 8'hFF, 1'b0);
    step(1'b0, STAT, 8'h00, 1'b0);
    chk("full_ovf_stat", dout, OVF_EN ? 8'hC8 : 8'h48);
    step(1'b1, STAT, 8'h02, 1'b0);
    step(1'b0, STAT, 8'h00, 1'b0);
    chk("clr_ovf_stat", dout, 8'h48);
    step(1'b1, DATA, 8'h55, 1'b1);
    step(1'b0, STAT, 8'h00, 1'b0);
    chk("full_pushpop_stat", dout, 8'h48);
    drained.delete();
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("drain_len", 8'(drained.size()), 8'd8);
    for (int i = 0; i < drained.size() && i < 8; i++)
      chk($sformatf("drain%0d", i), drained[i], i < 7 ? 8'h11 + 8'(i) : 8'h55);

    for (int i = 0; i < 5; i++) step(1'b1, DATA, 8'hA0 + 8'(i), 1'b0);
    step(1'b1, STAT, 8'h01, 1'b1);
    step(1'b0, STAT, 8'h00, 1'b0);
    chk("flush_stat", dout, 8'h20);
    chk("flush_valid", {7'b0, out_valid}, 8'h00);

    for (int i = 0; i < 4; i++) step(1'b1, DATA, 8'hC0 + 8'(i), 1'b0);
    step(1'b0, STAT, 8'h00, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_valid", {7'b0, out_valid}, 8'h00);
    chk("midrst_dout", dout, 8'h00);
    q.delete();
    ovf = 1'b0;
    @(negedge clk) rst = 1'b1;
    step(1'b0, STAT, 8'h00, 1'b0);
    chk("postrst_stat", dout, 8'h20);

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] a, d;
      bit rdy;
      r = $urandom_range(0, 9);
      a = r < 5 ? DATA : r < 7 ? STAT : ($urandom_range(0, 1) ? 8'h17 : 8'(r * 13));
      d = 8'($urandom);
      if (a == STAT) d[0] = ($urandom_range(0, 7) == 0);
      rdy = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0, a, d, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
